// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: owns the PC, keeps one memory request in flight,
// buffers the returned instruction for decode and drops wrong-path responses after a redirect.
module fetch_ctrl #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_decode,
  input  logic             i_pcsrc_decode,
  input  logic             i_jump_decode,
  input  logic [WIDTH-1:0] i_pc_branch,
  input  logic [WIDTH-1:0] i_pc_jump,
  output logic             o_mem_req,
  output logic [WIDTH-1:0] o_mem_addr,
  input  logic             i_mem_ready,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_fetch_valid,
  output logic [WIDTH-1:0] o_instr_fetch,
  output logic [WIDTH-1:0] o_pc_fetch
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_KILL = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc_fetch;
  logic             r_valid;

  logic             w_redirect;
  logic             w_consume;
  logic             w_buf_free;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_load;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_pc_next;

  // Decode-side control is only honoured when decode is actually advancing.
  assign w_redirect = (i_jump_decode | i_pcsrc_decode) & ~i_stall_decode;
  assign w_target   = i_jump_decode ? i_pc_jump : i_pc_branch;
  assign w_consume  = r_valid & ~i_stall_decode;
  assign w_buf_free = ~r_valid | w_consume;
  assign w_pc_inc   = r_pc + WIDTH'(4);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ:  w_next = w_redirect ? S_KILL : S_WAIT;
      S_WAIT: begin
        if (i_mem_ready)     w_next = (w_redirect || w_buf_free) ? S_REQ : S_HOLD;
        else if (w_redirect) w_next = S_KILL;
      end
      S_HOLD: if (!i_stall_decode) w_next = S_REQ;
      S_KILL: if (i_mem_ready) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = (r_state == S_REQ);
    o_mem_addr  = (r_state == S_REQ) ? r_pc : '0;
    w_load      = 1'b0;
    w_skid_load = 1'b0;
    w_load_data = i_mem_rdata;
    case (r_state)
      S_WAIT: begin
        w_load      = i_mem_ready & ~w_redirect & w_buf_free;
        w_skid_load = i_mem_ready & ~w_redirect & ~w_buf_free;
      end
      S_HOLD: begin
        w_load      = ~i_stall_decode & ~w_redirect;
        w_load_data = r_skid;
      end
      default: ;
    endcase
  end

  // pc always names the next instruction to fetch; it only advances once that instruction lands in the buffer.
  assign w_pc_next = w_redirect ? w_target : (w_load ? w_pc_inc : r_pc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_skid     <= '0;
      r_instr    <= '0;
      r_pc_fetch <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_skid_load) r_skid <= i_mem_rdata;
      if (w_load) begin
        r_instr    <= w_load_data;
        r_pc_fetch <= w_pc_inc;
        r_valid    <= 1'b1;
      end else if (w_consume || w_redirect) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_fetch_valid = r_valid;
  assign o_instr_fetch = r_instr;
  assign o_pc_fetch    = r_pc_fetch;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized bench for fetch_ctrl against an instruction-stream model
// with a variable-latency memory responder.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, pcsrc = 1'b0, jump = 1'b0;
  logic [31:0] pc_branch = '0, pc_jump = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        fetch_valid;
  logic [31:0] instr_fetch, pc_fetch;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_stall_decode(stall), .i_pcsrc_decode(pcsrc), .i_jump_decode(jump),
    .i_pc_branch(pc_branch), .i_pc_jump(pc_jump),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_fetch_valid(fetch_valid), .o_instr_fetch(instr_fetch), .o_pc_fetch(pc_fetch)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, n_cons = 0;
  int          lat_fix = 1;
  bit          spur = 1'b0;
  // memory responder state
  bit          outstanding = 1'b0;
  int          cnt = 0;
  logic [31:0] out_addr = '0;
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  // instruction-stream model: address the next consumed instruction must carry
  logic [31:0] exp_pc = '0;
  bit          exp_clear = 1'b0, exp_hold = 1'b0;
  logic [31:0] h_instr = '0, h_pc = '0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check last cycle's promises, play memory, drive decode, predict, advance.
  task automatic step(input logic st, input logic j, input logic b,
                      input logic [31:0] pb, input logic [31:0] pj);
    logic cons, red;
    if (exp_clear) check_eq("redirect_clears_valid", {31'b0, fetch_valid}, 32'd0);
    if (exp_hold) begin
      check_eq("hold_valid", {31'b0, fetch_valid}, 32'd1);
      check_eq("hold_instr", instr_fetch, h_instr);
      check_eq("hold_pc", pc_fetch, h_pc);
    end
    check_eq("one_outstanding", {31'b0, mem_req & outstanding}, 32'd0);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (outstanding) begin
      cnt--;
      if (cnt == 0) begin
        mem_ready   = 1'b1;
        mem_rdata   = imem(out_addr);
        outstanding = 1'b0;
      end
    end else if (!mem_req && spur && $urandom_range(0, 9) == 0) begin
      mem_ready = 1'b1;
    end
    if (mem_req) begin
      outstanding = 1'b1;
      out_addr    = mem_addr;
      cnt         = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      req_addr_q.push_back(mem_addr);
      req_cyc_q.push_back(cyc);
    end
    stall = st; jump = j; pcsrc = b; pc_branch = pb; pc_jump = pj;
    cons = fetch_valid & ~st;
    if (cons) begin
      check_eq("instr", instr_fetch, imem(exp_pc));
      check_eq("pc_fetch", pc_fetch, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    red = (j | b) & ~st;
    if (red) exp_pc = j ? pj : pb;
    exp_clear = red;
    exp_hold  = fetch_valid & st;
    h_instr   = instr_fetch;
    h_pc      = pc_fetch;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input bit stale);
    rst = 1'b1; stall = 1'b0; jump = 1'b0; pcsrc = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    check_eq("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check_eq("rst_instr", instr_fetch, 32'd0);
    check_eq("rst_pc_fetch", pc_fetch, 32'd0);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    outstanding = 1'b0; exp_pc = 32'h0; exp_clear = 1'b0; exp_hold = 1'b0;
    req_addr_q.delete(); req_cyc_q.delete();
    mem_ready = stale; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cyc++;
    mem_ready = 1'b0;
    check_eq("first_req", {31'b0, mem_req}, 32'd1);
    check_eq("first_req_addr", mem_addr, 32'h0);
    check_eq("first_req_valid", {31'b0, fetch_valid}, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && !mem_req; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    check_eq(tag, {31'b0, mem_req}, 32'd1);
  endtask

  initial begin
    int n0;
    // free run, 1-cycle memory
    do_reset(1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("freerun_addr%0d", i), req_addr_q[i], 32'(4 * i));
    for (int i = 0; i < 3; i++) check_eq($sformatf("freerun_gap%0d", i), 32'(req_cyc_q[i+1] - req_cyc_q[i]), 32'd2);

    // decode stall with response landing in the skid
    do_reset(1'b0);
    for (int i = 0; i < 20 && !(fetch_valid && pc_fetch == 32'h8); i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("hold_setup", {31'b0, fetch_valid && pc_fetch == 32'h8}, 32'd1);
    repeat (5) step(1'b1, 1'b0, 1'b0, '0, '0);
    check_eq("hold_frozen_pc", pc_fetch, 32'h8);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("release_valid", {31'b0, fetch_valid}, 32'd1);
    check_eq("release_pc", pc_fetch, 32'hC);
    check_eq("release_req", {31'b0, mem_req}, 32'd1);
    check_eq("release_addr", mem_addr, 32'hC);

    // branch during WAIT on 0x10 with 3-cycle memory
    do_reset(1'b0);
    lat_fix = 3;
    for (int i = 0; i < 60 && !(mem_req && mem_addr == 32'h10); i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("kill_setup", {31'b0, mem_req && mem_addr == 32'h10}, 32'd1);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h100, '0);
    check_eq("kill_valid", {31'b0, fetch_valid}, 32'd0);
    wait_req("kill_req_seen");
    check_eq("kill_target", mem_addr, 32'h100);

    // jump beats branch
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
    wait_req("jump_req_seen");
    check_eq("jump_wins", mem_addr, 32'h200);

    // pc wraps at the top of the address space
    step(1'b0, 1'b1, 1'b0, '0, 32'hFFFF_FFFC);
    wait_req("wrap_req_seen");
    check_eq("wrap_top", mem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    wait_req("wrap_next_seen");
    check_eq("wrap_zero", mem_addr, 32'h0);

    // redirects under stall are ignored
    repeat (6) step(1'b1, 1'b1, 1'b1, 32'h300, 32'h400);
    repeat (10) step(1'b0, 1'b0, 1'b0, '0, '0);

    // reset while in WAIT, stale response the next cycle
    wait_req("rst_wait_seen");
    step(1'b0, 1'b0, 1'b0, '0, '0);
    do_reset(1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, '0);

    // randomized traffic
    lat_fix = 0;
    spur    = 1'b1;
    n0      = n_cons;
    for (int i = 0; i < 3000; i++) begin
      logic st, rd, j, b;
      logic [31:0] pb, pj;
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 99) < 8);
      j  = rd & ($urandom_range(0, 1) == 1);
      b  = rd & (!j || ($urandom_range(0, 1) == 1));
      pb = $urandom & 32'hFFFF_FFFC;
      pj = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(st, j, b, pb, pj);
    end
    check_eq("random_progress", {31'b0, (n_cons - n0) > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
